clause_loader: RTL and testbench

Sequencer that feeds the clause registers of the unsatisfied-clause checker. A host writes integer and boolean clause coefficients into a local clause store, then pulses start. The loader streams each active clause to the checker over a valid/ready port and builds the per-clause checker enable mask. It raises done once the last clause has been accepted.

---
 rtl/clause_loader.sv | 140 ++++++++++++++
 tb/tb_clause_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_loader.sv
// clause_loader: local clause store plus a sequencer that streams
// active clauses to the unsatisfied-clause checker and builds its enable mask.
module clause_loader #(
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
  parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
  parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX          = 1,
  localparam int IW =
    (2 ** MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX + 1) *
    MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
  localparam int BW =
    MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT *
    (2 ** MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX),
  localparam int CI = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX,
  localparam int N  = 2 ** CI
) (
  input  logic          in_clk,
  input  logic          in_reset,
  input  logic          in_wr_en,
  input  logic [CI-1:0] in_wr_index,
  input  logic [IW-1:0] in_wr_integer,
  input  logic [BW-1:0] in_wr_boolean,
  input  logic [CI:0]   in_clause_count,
  input  logic          in_start,
  input  logic          in_clause_ready,
  output logic          out_clause_valid,
  output logic [IW-1:0] out_clause_coefficients_integer,
  output logic [BW-1:0] out_clause_coefficients_boolean,
  output logic [CI-1:0] out_clause_index,
  output logic [N-1:0]  out_checker_enable,
  output logic          out_busy,
  output logic          out_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CI:0] N_CNT = {1'b1, {CI{1'b0}}};

  state_t        state;
  logic [CI-1:0] idx;
  logic [CI:0]   count;
  logic [IW-1:0] store_int [N];
  logic [BW-1:0] store_bool[N];

  logic [CI:0]   cnt_sat;
  logic [CI-1:0] idx_nx;
  logic          is_last;
  logic          head_fwd;
  logic [IW-1:0] head_int;
  logic [BW-1:0] head_bool;

  // Saturate the count, find the last clause, and forward a same-edge
  // write into slot 0 so a start sees it.
  always_comb begin
    cnt_sat   = (in_clause_count > N_CNT) ? N_CNT : in_clause_count;
    idx_nx    = idx + 1'b1;
    is_last   = ({1'b0, idx} == (count - 1'b1));
    head_fwd  = in_wr_en && (in_wr_index == '0);
    head_int  = head_fwd ? in_wr_integer : store_int[0];
    head_bool = head_fwd ? in_wr_boolean : store_bool[0];
  end

  // Clause store: host writes only land while idle.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      for (int i = 0; i < N; i++) begin
        store_int[i]  <= '0;
        store_bool[i] <= '0;
      end
    end else if (state == IDLE && in_wr_en) begin
      store_int[in_wr_index]  <= in_wr_integer;
      store_bool[in_wr_index] <= in_wr_boolean;
    end
  end

  // Sequencer with registered outputs.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state                           <= IDLE;
      idx                             <= '0;
      count                           <= '0;
      out_clause_valid                <= 1'b0;
      out_clause_coefficients_integer <= '0;
      out_clause_coefficients_boolean <= '0;
      out_clause_index                <= '0;
      out_checker_enable              <= '0;
      out_busy                        <= 1'b0;
      out_done                        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_start) begin
            count              <= cnt_sat;
            idx                <= '0;
            out_checker_enable <= '0;
            out_busy           <= 1'b1;
            if (cnt_sat == '0) begin
              state    <= DONE;
              out_done <= 1'b1;
            end else begin
              state                           <= LOAD;
              out_clause_valid                <= 1'b1;
              out_clause_coefficients_integer <= head_int;
              out_clause_coefficients_boolean <= head_bool;
              out_clause_index                <= '0;
            end
          end
        end
        LOAD: begin
          if (in_clause_ready) begin
            out_checker_enable[idx] <= 1'b1;
            if (is_last) begin
              state            <= DONE;
              out_clause_valid <= 1'b0;
              out_done         <= 1'b1;
            end else begin
              idx                             <= idx_nx;
              out_clause_index                <= idx_nx;
              out_clause_coefficients_integer <= store_int[idx_nx];
              out_clause_coefficients_boolean <= store_bool[idx_nx];
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          idx      <= '0;
          out_done <= 1'b0;
          out_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// tb_clause_loader: directed and randomized checks of clause_loader
// against a clause-list model of the store and the expected transfer order.
module tb_clause_loader;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic        wr_index;
  logic [11:0] wr_int;
  logic [3:0]  wr_bool;
  logic [1:0]  cnt;
  logic        start;
  logic        ready;
  logic        valid;
  logic [11:0] c_int;
  logic [3:0]  c_bool;
  logic        c_index;
  logic [1:0]  enable;
  logic        busy;
  logic        done;

  logic [11:0] mi [2];
  logic [3:0]  mb [2];

  int n_cmp;
  int n_bad;

  clause_loader dut (
    .in_clk                          (clk),
    .in_reset                        (rst_n),
    .in_wr_en                        (wr_en),
    .in_wr_index                     (wr_index),
    .in_wr_integer                   (wr_int),
    .in_wr_boolean                   (wr_bool),
    .in_clause_count                 (cnt),
    .in_start                        (start),
    .in_clause_ready                 (ready),
    .out_clause_valid                (valid),
    .out_clause_coefficients_integer (c_int),
    .out_clause_coefficients_boolean (c_bool),
    .out_clause_index                (c_index),
    .out_checker_enable              (enable),
    .out_busy                        (busy),
    .out_done                        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit idx, input logic [11:0] iv,
                    input logic [3:0] bv);
    wr_en = 1'b1; wr_index = idx; wr_int = iv; wr_bool = bv;
    mi[idx] = iv; mb[idx] = bv;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int c, input bit w, input bit wi,
                          input logic [11:0] iv, input logic [3:0] bv);
    cnt = 2'(c); start = 1'b1;
    wr_en = w; wr_index = wi; wr_int = iv; wr_bool = bv;
    if (w) begin mi[wi] = iv; mb[wi] = bv; end
    step();
    start = 1'b0; wr_en = 1'b0;
  endtask

  // Called right after the start edge; walks the expected clause list.
  task automatic run_load(input int c, input int stall, input bit rnd,
                          input bit junk);
    int n;
    int k;
    int cyc;
    logic [1:0] m;
    n = (c > 2) ? 2 : c;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      m = 2'((1 << k) - 1);
      n_cmp++;
      if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_bad++;
        $display("FAIL load_flags k=%0d got v=%b b=%b d=%b want 1 1 0",
                 k, valid, busy, done);
      end
      n_cmp++;
      if (c_int !== mi[k] || c_bool !== mb[k]) begin
        n_bad++;
        $display("FAIL load_data k=%0d got %h/%b want %h/%b",
                 k, c_int, c_bool, mi[k], mb[k]);
      end
      n_cmp++;
      if (c_index !== 1'(k)) begin
        n_bad++;
        $display("FAIL load_index got %0d want %0d", c_index, k);
      end
      n_cmp++;
      if (enable !== m) begin
        n_bad++;
        $display("FAIL load_mask k=%0d got %b want %b", k, enable, m);
      end
      if (rnd) ready = 1'($urandom_range(0, 1));
      else     ready = (cyc >= stall);
      if (junk && cyc == 0) begin
        ready = 1'b0;
        wr_en = 1'b1; wr_index = 1'b1; wr_int = 12'hFFF; wr_bool = 4'hF;
        start = 1'b1; cnt = 2'd2;
      end
      step();
      wr_en = 1'b0; start = 1'b0;
      if (ready) k++;
      cyc++;
    end
    ready = 1'b0;
    if (cyc >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL load_timeout got k=%0d want %0d", k, n);
    end
    m = 2'((1 << n) - 1);
    n_cmp++;
    if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL done_flags got v=%b d=%b b=%b want 0 1 1",
               valid, done, busy);
    end
    n_cmp++;
    if (enable !== m) begin
      n_bad++;
      $display("FAIL done_mask got %b want %b", enable, m);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0 || enable !== m) begin
      n_bad++;
      $display("FAIL idle_after got d=%b b=%b v=%b en=%b want 0 0 0 %b",
               done, busy, valid, enable, m);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_index = 1'b0; wr_int = '0; wr_bool = '0;
    cnt = '0; start = 1'b0; ready = 1'b0;
    mi[0] = '0; mi[1] = '0; mb[0] = '0; mb[1] = '0;
    step(); step();
    n_cmp++;
    if ({valid, c_int, c_bool, c_index, enable, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 0",
               {valid, c_int, c_bool, c_index, enable, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    wr(1'b0, 12'h3A1, 4'b1001);
    wr(1'b1, 12'h5F2, 4'b0110);
    do_start(2, 0, 0, '0, '0);
    run_load(2, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    do_start(2, 0, 0, '0, '0);
    run_load(2, 3, 0, 0);
  endtask

  task automatic test_count_edges();
    do_start(0, 0, 0, '0, '0);
    run_load(0, 0, 0, 0);
    do_start(3, 0, 0, '0, '0);
    run_load(3, 0, 0, 0);
    do_start(1, 0, 0, '0, '0);
    run_load(1, 0, 0, 0);
  endtask

  task automatic test_busy_writes();
    do_start(2, 0, 0, '0, '0);
    run_load(2, 1, 0, 1);
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start got busy=%b want 0", busy);
    end
    do_start(2, 0, 0, '0, '0);
    run_load(2, 0, 0, 0);
  endtask

  task automatic test_reset_mid_load();
    do_start(2, 0, 0, '0, '0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    n_cmp++;
    if (c_index !== 1'b1 || valid !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_index got %b/%b want 1/1", c_index, valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({valid, c_int, c_bool, c_index, enable, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got %h want 0",
               {valid, c_int, c_bool, c_index, enable, busy, done});
    end
    mi[0] = '0; mi[1] = '0; mb[0] = '0; mb[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_start(2, 0, 0, '0, '0);
    run_load(2, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int nw;
      int c;
      bit sw;
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++)
        wr(1'($urandom_range(0, 1)), 12'($urandom), 4'($urandom));
      c = $urandom_range(0, 3);
      sw = 1'($urandom_range(0, 1));
      do_start(c, sw, 1'($urandom_range(0, 1)), 12'($urandom), 4'($urandom));
      run_load(c, 0, 1, 0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_count_edges();
    test_busy_writes();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
